// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int unsigned N_REQ           = 8;
  localparam int unsigned IDX_W           = 3;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage : rr_arbiter8_pkg

// File: rtl/rr_arbiter8_pick.sv
// rr_pick8: combinational rotating priority encoder; idx is the first set req bit
// scanning ptr, ptr+1, ... ptr+7 (mod 8); any flags that some bit is set.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    idx  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule : rr_pick8

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter driving a 3-to-8 decoder (x, en).
// Define RR_ARBITER8_TIMEOUT_EN to cap each grant at TIMEOUT cycles.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             release_grant,  // owner ends its grant (release is a reserved word)
  output logic [IDX_W-1:0] x,
  output logic             en
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_arbiter8: TIMEOUT must be in 2..255");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] x_q, x_d;
  logic             en_q, en_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             grant_exit;

`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state: grants always pass back through IDLE, giving an en=0 gap.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    x_d        = x_q;
    en_d       = en_q;
    grant_exit = 1'b0;
`ifdef RR_ARBITER8_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (pick_any) begin
          state_d = ST_GRANT;
          x_d     = pick_idx;
          en_d    = 1'b1;
`ifdef RR_ARBITER8_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        grant_exit = release_grant || !req[x_q];
`ifdef RR_ARBITER8_TIMEOUT_EN
        if (cnt_q == TO_LAST) grant_exit = 1'b1;
`endif
        if (grant_exit) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          ptr_d   = x_q + IDX_W'(1);
        end else begin
`ifdef RR_ARBITER8_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      x_q     <= '0;
      en_q    <= 1'b0;
`ifdef RR_ARBITER8_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      x_q     <= x_d;
      en_q    <= en_d;
`ifdef RR_ARBITER8_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign x  = x_q;
  assign en = en_q;

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8; expected grant sequences are worked out by hand.
module tb_rr_arbiter8;

  localparam int unsigned TB_TIMEOUT = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [2:0] x;
  logic       en;

  int total = 0;
  int bad   = 0;

  rr_arbiter8 #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .release_grant (rel),
    .x             (x),
    .en            (en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic en_exp, input logic [2:0] x_exp);
    total++;
    assert ((en === en_exp) && (x === x_exp))
    else begin
      bad++;
      $error("FAIL %s: got en=%0b x=%0d, expected en=%0b x=%0d", tag, en, x, en_exp, x_exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    rel   = 1'b0;
    step();
    step();
    chk("reset", 1'b0, 3'd0);
    rst_n = 1'b1;

    // Sole requester 0: grant, gap, re-grant.
    req = 8'h01;
    step(); chk("solo_grant0", 1'b1, 3'd0);
    rel = 1'b1;
    step(); chk("solo_gap0", 1'b0, 3'd0);
    rel = 1'b0;
    step(); chk("solo_grant1", 1'b1, 3'd0);
    rel = 1'b1;
    step(); chk("solo_gap1", 1'b0, 3'd0);
    rel = 1'b0;
    req = 8'h00;

    // Reset returns ptr to 0, then idle with no requests.
    rst_n = 1'b0;
    step(); chk("reset2", 1'b0, 3'd0);
    rst_n = 1'b1;
    step(); chk("idle_noreq", 1'b0, 3'd0);

    // All requesters: strict rotation 0..7 then 0.
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step(); chk("rr_grant", 1'b1, 3'(k % 8));
      rel = 1'b1;
      step(); chk("rr_gap", 1'b0, 3'(k % 8));
      rel = 1'b0;
    end
    req = 8'h00;

    // Move ptr to 6 via a grant at 5, then wrap 6 -> 0.
    req = 8'h20;
    step(); chk("set_ptr_grant5", 1'b1, 3'd5);
    rel = 1'b1;
    step(); chk("set_ptr_gap", 1'b0, 3'd5);
    rel = 1'b0;
    req = 8'h41;
    step(); chk("wrap_grant6", 1'b1, 3'd6);
    rel = 1'b1;
    step(); chk("wrap_gap", 1'b0, 3'd6);
    rel = 1'b0;
    step(); chk("wrap_grant0", 1'b1, 3'd0);
    rel = 1'b1;
    step(); chk("wrap_gap0", 1'b0, 3'd0);

    // Release while idle does nothing; still ignored when a request appears.
    req = 8'h00;
    step(); chk("idle_release", 1'b0, 3'd0);
    req = 8'h08;
    step(); chk("grant3", 1'b1, 3'd3);
    rel = 1'b0;
    req = 8'hF8;
    step(); chk("grant3_hold", 1'b1, 3'd3);
    req = 8'hF0;
    step(); chk("drop_req3", 1'b0, 3'd3);
    step(); chk("search_from4", 1'b1, 3'd4);

    // release and req drop together advance ptr once (to 5, not 6).
    req = 8'hE0;
    rel = 1'b1;
    step(); chk("double_exit", 1'b0, 3'd4);
    rel = 1'b0;
    req = 8'h60;
    step(); chk("ptr_once", 1'b1, 3'd5);

    // Mid-grant reset at x=5.
    rst_n = 1'b0;
    req   = 8'h30;
    step(); chk("midgrant_reset", 1'b0, 3'd0);
    rst_n = 1'b1;
    step(); chk("post_reset_grant4", 1'b1, 3'd4);
    step(); chk("grant4_hold", 1'b1, 3'd4);

    // Long hold of a single requester with release low.
    rst_n = 1'b0;
    req   = 8'h04;
    step(); chk("reset3", 1'b0, 3'd0);
    rst_n = 1'b1;
`ifdef RR_ARBITER8_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      step(); chk("timeout_high", 1'b1, 3'd2);
    end
    step(); chk("timeout_gap", 1'b0, 3'd2);
    step(); chk("timeout_regrant", 1'b1, 3'd2);
`else
    for (int k = 0; k < 6; k++) begin
      step(); chk("long_hold", 1'b1, 3'd2);
    end
    rel = 1'b1;
    step(); chk("long_release", 1'b0, 3'd2);
    rel = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rr_arbiter8

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001: Parameter TIMEOUT, default 16: maximum cycles one grant is held; used only when RR_ARBITER8_TIMEOUT_EN is defined; legal range 2..255.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004: req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005: release  input  1  current owner ends its grant; sampled only in GRANT.
REQ-006: x  output  3  granted requester index; feeds the x input of the downstream 3-to-8 decoder.
REQ-007: en  output  1  grant valid; feeds the en input of the downstream 3-to-8 decoder.

Function
REQ-008: Two-state FSM, IDLE and GRANT, one-hot or binary encoding at implementer's choice.
REQ-009: Internal 3-bit pointer ptr marks the highest-priority index; search order is ptr, ptr+1, ... ptr+7, modulo 8.
REQ-010: IDLE with req==0: remain IDLE, en=0, x holds its previous value.
REQ-011: IDLE with req!=0: next edge enter GRANT, en=1, x = first set bit of req in search order; latency exactly 1 cycle from req sampled to en=1.
REQ-012: GRANT: x is stable and en=1 until exit; changes on other req bits are ignored.
REQ-013: Exit GRANT on the edge where release==1 or req[x]==0: next state IDLE, en=0, ptr = x+1 modulo 8 (7 wraps to 0).
REQ-014: en is low for at least one full cycle between consecutive grants, so decoder outputs never overlap.
REQ-015: release asserted while in IDLE has no effect.
REQ-016: release==1 and req[x]==0 in the same cycle count as one exit event; ptr advances once.
REQ-017: A sole persistent requester is re-granted after each one-cycle gap; no starvation for any asserted req bit within 8 grants.

Reset
REQ-018: rst_n==0 at a rising edge forces state=IDLE, en=0, x=3'b000, ptr=3'b000, and timeout counter=0, including mid-grant.
REQ-019: On the first edge after rst_n returns high, the arbiter behaves as IDLE with ptr=0.

Configuration
REQ-020: Macro RR_ARBITER8_TIMEOUT_EN defined: an 8-bit counter clears on GRANT entry, increments each GRANT cycle, and forces a REQ-013 exit on the edge where it reaches TIMEOUT-1, so en is high for at most TIMEOUT cycles.
REQ-021: Macro RR_ARBITER8_TIMEOUT_EN undefined: no counter is built; a grant lasts until release or req[x] drops.

Structure
REQ-022: Package rr_arbiter8_pkg holds N_REQ=8, IDX_W=3, the FSM state typedef, and the TIMEOUT default constant.
REQ-023: Sub-module rr_pick8 is a purely combinational rotating priority encoder: inputs req[7:0] and ptr[2:0]; outputs idx[2:0] and any.
REQ-024: Top-level rr_arbiter8 contains only the FSM, the ptr register, the x/en registers, and the optional counter.

Verification
REQ-025: Reset, then req=8'h01 held with release pulsed 1 cycle after each grant -> en=1 with x=0, then 1 low cycle, then x=0 again, repeating.
REQ-026: After reset, req=8'hFF held with release pulsed on each grant -> x sequence 0,1,2,...,7,0 with one en=0 cycle between grants.
REQ-027: ptr=6 with req=8'h41 -> grant x=6; after release, grant x=0 (wrap-around).
REQ-028: In GRANT x=3, drop req[3] with release=0 -> en=0 next cycle, next grant searches from 4.
REQ-029: Assert rst_n=0 for one cycle mid-grant at x=5 -> en=0 and x=0 the next cycle; with req=8'h30, next grant x=4.
REQ-030: With RR_ARBITER8_TIMEOUT_EN, TIMEOUT=4, req=8'h04, release=0 -> en high for exactly 4 cycles, low 1, high again.
